// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared state encoding, direction and port constants for ram_arbiter
package ram_arb_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 4;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_AUX = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/ram_arbiter_rr_pick2.sv
// rtl/ram_arbiter_rr_pick2.sv - two-way request picker (round-robin, or CPU priority with RAM_ARB_FIXED_PRIO_EN)
module rr_pick2
    import ram_arb_pkg::*;
(
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_last,
    output logic o_winner,
    output logic o_any_req
);

`ifdef RAM_ARB_FIXED_PRIO_EN
    logic w_unused_last;
    assign w_unused_last = i_last;
`endif

    always_comb begin
        o_any_req = i_req0 | i_req1;
        o_winner  = PORT_CPU;
        if (i_req0 && i_req1) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
            o_winner = PORT_CPU;
`else
            // On a tie the port that did not win last time goes next
            o_winner = ~i_last;
`endif
        end else if (i_req1) begin
            o_winner = PORT_AUX;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - shares one single-port sync RAM between CPU (port 0) and loader (port 1); option RAM_ARB_FIXED_PRIO_EN
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              rw0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic [DATA_W-1:0] rdata0,
    output logic              rvalid0,
    input  logic              req1,
    input  logic              rw1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic [DATA_W-1:0] rdata1,
    output logic              rvalid1,
    output logic              ram_RW,
    output logic              ram_EN,
    output logic [ADDR_W-1:0] ram_address_bus,
    output logic [DATA_W-1:0] ram_data_bus_c2r,
    input  logic [DATA_W-1:0] ram_data_bus_r2c
);

    arb_state_t r_state;
    logic       r_last;
    logic       r_sel;
    logic       w_winner;
    logic       w_any_req;

    rr_pick2 u_pick (
        .i_req0    (req0),
        .i_req1    (req1),
        .i_last    (r_last),
        .o_winner  (w_winner),
        .o_any_req (w_any_req)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state          <= ST_IDLE;
            r_last           <= PORT_AUX;
            r_sel            <= PORT_CPU;
            ram_EN           <= 1'b0;
            ram_RW           <= RW_READ;
            ram_address_bus  <= '0;
            ram_data_bus_c2r <= '0;
            gnt0             <= 1'b0;
            gnt1             <= 1'b0;
            rvalid0          <= 1'b0;
            rvalid1          <= 1'b0;
            rdata0           <= '0;
            rdata1           <= '0;
        end else begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_sel  <= w_winner;
                        r_last <= w_winner;
                        ram_EN <= 1'b1;
                        if (w_winner == PORT_AUX) begin
                            ram_RW           <= rw1;
                            ram_address_bus  <= addr1;
                            ram_data_bus_c2r <= wdata1;
                            gnt1             <= 1'b1;
                        end else begin
                            ram_RW           <= rw0;
                            ram_address_bus  <= addr0;
                            ram_data_bus_c2r <= wdata0;
                            gnt0             <= 1'b1;
                        end
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // Address/data stay parked; only the enable and grant are one-cycle pulses
                    ram_EN  <= 1'b0;
                    gnt0    <= 1'b0;
                    gnt1    <= 1'b0;
                    r_state <= (ram_RW == RW_READ) ? ST_RESP : ST_IDLE;
                end
                ST_RESP: begin
                    if (r_sel == PORT_AUX) begin
                        rdata1  <= ram_data_bus_r2c;
                        rvalid1 <= 1'b1;
                    end else begin
                        rdata0  <= ram_data_bus_r2c;
                        rvalid0 <= 1'b1;
                    end
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - self-checking bench for ram_arbiter (honours RAM_ARB_FIXED_PRIO_EN)
module tb_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0 = 1'b0, rw0 = 1'b1, req1 = 1'b0, rw1 = 1'b1;
    logic [7:0] addr0 = '0, addr1 = '0;
    logic [3:0] wdata0 = '0, wdata1 = '0;
    logic       gnt0, gnt1, rvalid0, rvalid1;
    logic [3:0] rdata0, rdata1;
    logic       ram_RW, ram_EN;
    logic [7:0] ram_address_bus;
    logic [3:0] ram_data_bus_c2r;
    logic [3:0] ram_data_bus_r2c;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.ADDR_W(8), .DATA_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .rw0(rw0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rdata0(rdata0), .rvalid0(rvalid0),
        .req1(req1), .rw1(rw1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rdata1(rdata1), .rvalid1(rvalid1),
        .ram_RW(ram_RW), .ram_EN(ram_EN), .ram_address_bus(ram_address_bus),
        .ram_data_bus_c2r(ram_data_bus_c2r), .ram_data_bus_r2c(ram_data_bus_r2c)
    );

    // Behavioural single-port synchronous RAM
    logic       init_mem;
    logic [3:0] tb_mem [256];
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 256; i++)
                tb_mem[i] <= (i == 1) ? 4'h7 : ((i == 2) ? 4'h9 : 4'h0);
        end else if (ram_EN) begin
            if (ram_RW) ram_data_bus_r2c <= tb_mem[ram_address_bus];
            else        tb_mem[ram_address_bus] <= ram_data_bus_c2r;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic p, input logic rq, input logic rw, input logic [7:0] a, input logic [3:0] d);
        if (p) begin req1 = rq; rw1 = rw; addr1 = a; wdata1 = d; end
        else   begin req0 = rq; rw0 = rw; addr0 = a; wdata0 = d; end
    endtask

    task automatic do_reset;
        req0 = 1'b0; req1 = 1'b0;
        rst_n = 1'b0;
        tick; tick;
        rst_n = 1'b1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_en"}, ram_EN, 1'b0);
        chk({tag, "_rw"}, ram_RW, 1'b1);
        chk({tag, "_addr"}, ram_address_bus, 8'h00);
        chk({tag, "_c2r"}, ram_data_bus_c2r, 4'h0);
        chk({tag, "_gnt"}, {gnt0, gnt1}, 2'b00);
        chk({tag, "_rvalid"}, {rvalid0, rvalid1}, 2'b00);
        chk({tag, "_rdata"}, {rdata0, rdata1}, 8'h00);
    endtask

    // One isolated access from an idle arbiter, checked cycle by cycle
    task automatic access(input logic p, input logic rw, input logic [7:0] a, input logic [3:0] d,
                          input logic [3:0] exp_rd);
        drive(p, 1'b1, rw, a, d);
        tick;
        chk("vec_gnt", {gnt1, gnt0}, p ? 2'b10 : 2'b01);
        chk("vec_en", ram_EN, 1'b1);
        chk("vec_rw", ram_RW, rw);
        chk("vec_addr", ram_address_bus, a);
        chk("vec_c2r", ram_data_bus_c2r, d);
        drive(p, 1'b0, rw, a, d);
        tick;
        chk("vec_en_off", {ram_EN, gnt0, gnt1}, 3'b000);
        if (rw) begin
            chk("vec_rv_early", {rvalid1, rvalid0}, 2'b00);
            tick;
            chk("vec_rv", {rvalid1, rvalid0}, p ? 2'b10 : 2'b01);
            chk("vec_rdata", p ? rdata1 : rdata0, exp_rd);
            tick;
            chk("vec_rv_pulse", {rvalid1, rvalid0}, 2'b00);
            chk("vec_rdata_hold", p ? rdata1 : rdata0, exp_rd);
        end
    endtask

    typedef struct {
        logic       port;
        logic       rw;
        logic [7:0] addr;
        logic [3:0] wd;
        logic [3:0] exp_rd;
    } vec_t;

    vec_t vt[8];

    // Reference model state for the random phase
    localparam int NR = 400;
    logic       e_en [NR+4];
    logic       e_g0 [NR+4];
    logic       e_g1 [NR+4];
    logic       e_rv0[NR+4];
    logic       e_rv1[NR+4];
    logic       e_rw [NR+4];
    logic [7:0] e_addr[NR+4];
    logic [3:0] e_wd [NR+4];
    logic [3:0] e_rd0[NR+4];
    logic [3:0] e_rd1[NR+4];
    logic [3:0] m_mem[256];
    logic       p_req[2];
    logic       p_rw [2];
    logic [7:0] p_addr[2];
    logic [3:0] p_wd [2];

    task automatic new_req(input int p);
        p_req[p]  = 1'b1;
        p_rw[p]   = 1'($urandom_range(0, 1));
        p_addr[p] = 8'h80 + 8'($urandom_range(0, 7));
        p_wd[p]   = 4'($urandom_range(0, 15));
    endtask

    initial begin
        int   gq[$];
        int   exp_ord[5];
        int   rv0_cnt, rv1_cnt, free_at, w;
        logic prev_en, seen, m_last, both;

        vt[0] = '{1'b0, 1'b0, 8'h3C, 4'hA, 4'h0};
        vt[1] = '{1'b0, 1'b1, 8'h3C, 4'h0, 4'hA};
        vt[2] = '{1'b1, 1'b0, 8'hFF, 4'h5, 4'h0};
        vt[3] = '{1'b1, 1'b1, 8'hFF, 4'h0, 4'h5};
        vt[4] = '{1'b0, 1'b1, 8'hFF, 4'h0, 4'h5};
        vt[5] = '{1'b1, 1'b0, 8'h00, 4'hF, 4'h0};
        vt[6] = '{1'b0, 1'b1, 8'h00, 4'h0, 4'hF};
        vt[7] = '{1'b1, 1'b1, 8'h3C, 4'h0, 4'hA};

        init_mem = 1'b1;
        rst_n = 1'b0;
        tick;
        init_mem = 1'b0;
        tick;
        chk_reset_vals("reset");
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick;
            chk("idle_quiet", {ram_EN, gnt0, gnt1, rvalid0, rvalid1}, 5'b0);
        end

        for (int i = 0; i < 8; i++)
            access(vt[i].port, vt[i].rw, vt[i].addr, vt[i].wd, vt[i].exp_rd);

        // Both ports stream reads from reset: first tie goes to port 0
        do_reset;
        drive(1'b0, 1'b1, 1'b1, 8'h01, 4'h0);
        drive(1'b1, 1'b1, 1'b1, 8'h02, 4'h0);
`ifdef RAM_ARB_FIXED_PRIO_EN
        exp_ord = '{0, 0, 0, 0, 0};
`else
        exp_ord = '{0, 1, 0, 1, 0};
`endif
        prev_en = 1'b0; rv0_cnt = 0; rv1_cnt = 0;
        for (int k = 1; k <= 14; k++) begin
            tick;
            if (gnt0) gq.push_back(0);
            if (gnt1) gq.push_back(1);
            if (ram_EN && prev_en) chk("stream_en_gap", 1'b1, 1'b0);
            prev_en = ram_EN;
            if (rvalid0) begin
                rv0_cnt++;
                chk("stream_rdata0", rdata0, 4'h7);
                chk("stream_rv_excl0", rvalid1, 1'b0);
            end
            if (rvalid1) begin
                rv1_cnt++;
                chk("stream_rdata1", rdata1, 4'h9);
            end
        end
        chk("stream_grants", gq.size(), 5);
        for (int i = 0; i < 5 && i < gq.size(); i++) chk("stream_order", gq[i], exp_ord[i]);
`ifdef RAM_ARB_FIXED_PRIO_EN
        chk("stream_rv_counts", {rv0_cnt[7:0], rv1_cnt[7:0]}, {8'd4, 8'd0});
`else
        chk("stream_rv_counts", {rv0_cnt[7:0], rv1_cnt[7:0]}, {8'd2, 8'd2});
`endif
        drive(1'b0, 1'b0, 1'b1, 8'h0, 4'h0);
        drive(1'b1, 1'b0, 1'b1, 8'h0, 4'h0);
        for (int i = 0; i < 6; i++) tick;

        // A port 1 request visible only while the arbiter is busy is never granted
        drive(1'b0, 1'b1, 1'b0, 8'h50, 4'h3);
        tick;
        chk("drop_gnt0", gnt0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 8'h50, 4'h3);
        drive(1'b1, 1'b1, 1'b0, 8'h51, 4'h4);
        tick;
        drive(1'b1, 1'b0, 1'b0, 8'h51, 4'h4);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick;
            if (gnt1 || ram_EN) seen = 1'b1;
        end
        chk("drop_no_grant", seen, 1'b0);

        // Reset during RESP of a port 1 read
        drive(1'b1, 1'b1, 1'b1, 8'h02, 4'h0);
        tick;
        chk("rst_gnt1", gnt1, 1'b1);
        drive(1'b1, 1'b0, 1'b1, 8'h02, 4'h0);
        tick;
        rst_n = 1'b0;
        tick;
        chk_reset_vals("midrst");
        rst_n = 1'b1;
        drive(1'b0, 1'b1, 1'b1, 8'h01, 4'h0);
        drive(1'b1, 1'b1, 1'b1, 8'h02, 4'h0);
        tick;
        chk("post_rst_gnt", {gnt1, gnt0}, 2'b01);
        drive(1'b0, 1'b0, 1'b1, 8'h01, 4'h0);
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            tick;
            if (gnt1) seen = 1'b1;
        end
        chk("post_rst_gnt1_follows", seen, 1'b1);
        drive(1'b1, 1'b0, 1'b1, 8'h02, 4'h0);
        for (int i = 0; i < 5; i++) tick;

`ifdef RAM_ARB_FIXED_PRIO_EN
        // CPU held continuously starves port 1 until it lets go
        drive(1'b0, 1'b1, 1'b0, 8'h60, 4'h1);
        drive(1'b1, 1'b1, 1'b0, 8'h61, 4'h2);
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick;
            if (gnt1) seen = 1'b1;
        end
        chk("prio_starve", seen, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 8'h60, 4'h1);
        seen = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            tick;
            if (gnt1) seen = 1'b1;
        end
        chk("prio_gnt1_after_drop", seen, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 8'h61, 4'h2);
        for (int i = 0; i < 4; i++) tick;
`endif

        // Random traffic against a cycle-budget transaction model
        for (int k = 0; k < NR + 4; k++) begin
            e_en[k] = 0; e_g0[k] = 0; e_g1[k] = 0; e_rv0[k] = 0; e_rv1[k] = 0;
            e_rw[k] = 0; e_addr[k] = 0; e_wd[k] = 0; e_rd0[k] = 0; e_rd1[k] = 0;
        end
        for (int a = 8'h80; a < 8'h88; a++) m_mem[a] = 4'h0;
        for (int p = 0; p < 2; p++) begin
            p_req[p] = 0; p_rw[p] = 1; p_addr[p] = 8'h80; p_wd[p] = 0;
        end
        do_reset;
        free_at = 0;
        m_last = 1'b1;
        for (int k = 0; k < NR; k++) begin
            chk("rnd_en", ram_EN, e_en[k]);
            chk("rnd_gnt", {gnt1, gnt0}, {e_g1[k], e_g0[k]});
            chk("rnd_rvalid", {rvalid1, rvalid0}, {e_rv1[k], e_rv0[k]});
            if (e_en[k]) begin
                chk("rnd_rw", ram_RW, e_rw[k]);
                chk("rnd_addr", ram_address_bus, e_addr[k]);
                chk("rnd_c2r", ram_data_bus_c2r, e_wd[k]);
            end
            if (e_rv0[k]) chk("rnd_rdata0", rdata0, e_rd0[k]);
            if (e_rv1[k]) chk("rnd_rdata1", rdata1, e_rd1[k]);

            for (int p = 0; p < 2; p++) begin
                if ((p == 0) ? e_g0[k] : e_g1[k]) begin
                    if ($urandom_range(0, 3) == 0) p_req[p] = 1'b0;
                    else new_req(p);
                end else if (!p_req[p] && $urandom_range(0, 2) == 0) begin
                    new_req(p);
                end
            end
            drive(1'b0, p_req[0], p_rw[0], p_addr[0], p_wd[0]);
            drive(1'b1, p_req[1], p_rw[1], p_addr[1], p_wd[1]);

            if (k == free_at) begin
                if (p_req[0] || p_req[1]) begin
                    both = p_req[0] && p_req[1];
`ifdef RAM_ARB_FIXED_PRIO_EN
                    w = both ? 0 : (p_req[1] ? 1 : 0);
`else
                    w = both ? (m_last ? 0 : 1) : (p_req[1] ? 1 : 0);
`endif
                    m_last = w[0];
                    e_en[k+1] = 1'b1;
                    if (w == 1) e_g1[k+1] = 1'b1; else e_g0[k+1] = 1'b1;
                    e_rw[k+1] = p_rw[w];
                    e_addr[k+1] = p_addr[w];
                    e_wd[k+1] = p_wd[w];
                    if (p_rw[w]) begin
                        if (w == 1) begin e_rv1[k+3] = 1'b1; e_rd1[k+3] = m_mem[p_addr[w]]; end
                        else        begin e_rv0[k+3] = 1'b1; e_rd0[k+3] = m_mem[p_addr[w]]; end
                        free_at = k + 3;
                    end else begin
                        m_mem[p_addr[w]] = p_wd[w];
                        free_at = k + 2;
                    end
                end else begin
                    free_at = k + 1;
                end
            end
            tick;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
